load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU: takes ALUResult as the effective address and performs RV32I loads and stores against a data-memory port with a request/ready/rvalid handshake.
- Generates byte enables and lane-replicated write data for stores, and extracts and sign/zero-extends load data.
- Holds the pipeline with Stall until the access finishes.
- Flags misaligned or unsupported accesses without touching memory.

Parameters:
- DATA_WIDTH, 32, data and address width. Only 32 is supported.
- BE_WIDTH, 4, byte-enable width. Must equal DATA_WIDTH/8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- MemRead  input  1  load requested this cycle.
- MemWrite  input  1  store requested this cycle.
- Funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResult  input  DATA_WIDTH  effective byte address.
- WriteData  input  DATA_WIDTH  store data, right-aligned.
- Stall  output  1  holds upstream pipeline stages.
- ReadData  output  DATA_WIDTH  extended load result.
- LoadValid  output  1  ReadData valid this cycle, one-cycle pulse.
- AccessFault  output  1  rejected access, one-cycle pulse.
- MemReq  output  1  memory request valid.
- MemWe  output  1  1 = write, 0 = read.
- MemAddr  output  DATA_WIDTH  word-aligned address, bits [1:0] = 0.
- MemByteEn  output  BE_WIDTH  write byte lanes.
- MemWData  output  DATA_WIDTH  lane-replicated store data.
- MemReady  input  1  memory accepts request this cycle.
- MemRValid  input  1  read data valid.
- MemRData  input  DATA_WIDTH  read word.

Behaviour:
- Reset: synchronous, active-high. At the edge with rst=1: state goes to IDLE; ReadData, LoadValid, AccessFault, MemReq, MemWe, MemAddr, MemByteEn, MemWData all go to 0.
- Reset mid-transaction abandons the access. MemReq is low from the following cycle; no LoadValid is produced.
- States are IDLE, REQ, WAIT_R, DONE.

IDLE:
- Start condition is MemRead xor MemWrite.
- Fault conditions, all with no memory access:
  - MemRead and MemWrite both high.
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - Funct3 in {011, 110, 111}.
  - A store with Funct3 100 or 101.
- On a fault: AccessFault=1 next cycle, Stall=0, stay IDLE.
- Valid start: capture address, Funct3, direction, byte enables and write data; go to REQ. Stall=1 combinationally in this same cycle.
- Stall = (state≠IDLE && state≠DONE) || (IDLE && valid start).

REQ:
- MemReq=1; MemAddr, MemWe, MemByteEn, MemWData held stable until MemReady=1.
- Store with MemReady: go to DONE.
- Load with MemReady: go to WAIT_R.
- A MemRValid seen in REQ is ignored.

WAIT_R:
- MemReq=0. On MemRValid, register the extracted value into ReadData and go to DONE.

DONE:
- Stall=0; LoadValid=1 for loads only. The pipeline advances this cycle.
- MemRead/MemWrite are ignored this cycle; unconditionally go to IDLE.
- ReadData holds its value until the next load completes.

Byte enables (off = addr[1:0]):
- B: 0001<<off. H: 0011<<off. W: 1111.
- MemByteEn = 0 for loads.

Write data:
- B: byte replicated ×4.
- H: halfword replicated ×2.
- W: unchanged.

Load extraction:
- Lane = MemRData >> (8·off).
- B/H: sign-extend from bit 7/15.
- BU/HU: zero-extend.
- W: unchanged.

Latency:
- Store: minimum 2 cycles of Stall (IDLE-start, REQ), DONE on cycle 3.
- Load: minimum 3 cycles of Stall, then DONE.
- Unbounded waits on MemReady/MemRValid; there is no timeout.

Test Plan:
- SW: addr 0x100, data 0xDEADBEEF, MemReady immediate -> MemAddr 0x100, MemByteEn 1111, MemWData 0xDEADBEEF, Stall high 2 cycles, then DONE with LoadValid=0.
- SB: addr 0x203, data 0x000000A5 -> MemAddr 0x200, MemByteEn 1000, MemWData 0xA5A5A5A5.
- LB/LBU: addr 0x102, MemRData 0x12F45678 -> LB ReadData 0xFFFFFFF4 and LBU 0x000000F4, each with a single LoadValid pulse.
- LH: addr 0x102, MemRData 0x80011234 -> ReadData 0xFFFF8001.
- Backpressure: MemReady low for 3 cycles in REQ, then MemRValid 2 cycles after acceptance -> request fields stable throughout, Stall continuous, LoadValid exactly once.
- Faults:
  - LW at 0x102 -> AccessFault pulse, MemReq never asserted, Stall=0.
  - MemRead=MemWrite=1 -> AccessFault.
  - rst asserted in WAIT_R -> next cycle IDLE, MemReq=0, no LoadValid.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store memory stage with request/ready/rvalid handshake
// Faulting accesses are rejected in IDLE and never reach the memory port.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Stall,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  LoadValid,
  output logic                  AccessFault,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [DATA_WIDTH-1:0] MemAddr,
  output logic [BE_WIDTH-1:0]   MemByteEn,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic                  MemReady,
  input  logic                  MemRValid,
  input  logic [DATA_WIDTH-1:0] MemRData
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  fault_q, fault_d;

  logic                  access;
  logic                  fault;
  logic                  start;
  logic [1:0]            off;
  logic [BE_WIDTH-1:0]   be_new;
  logic [DATA_WIDTH-1:0] wdata_new;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_ext;

  assign off    = ALUResult[1:0];
  assign access = MemRead | MemWrite;

  always_comb begin
    fault = 1'b0;
    if (MemRead && MemWrite)                               fault = 1'b1;
    if (Funct3 == 3'b011 || Funct3[2:1] == 2'b11)          fault = 1'b1;
    if (MemWrite && Funct3[2])                             fault = 1'b1;
    if (Funct3[1:0] == 2'b01 && off[0])                    fault = 1'b1;
    if (Funct3 == 3'b010 && off != 2'b00)                  fault = 1'b1;
  end

  assign start = access && !fault;

  // Stores place the right-aligned datum on every lane; byte enables pick the lane.
  always_comb begin
    be_new    = '0;
    wdata_new = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << off;
        wdata_new = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << off;
        wdata_new = {2{WriteData[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = WriteData;
      end
    endcase
  end

  assign lane = MemRData >> {off_q, 3'b000};

  always_comb begin
    load_ext = lane;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_ext = {24'b0, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_ext = {16'b0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    fault_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && fault) begin
          fault_d = 1'b1;
        end else if (start) begin
          addr_d   = {ALUResult[DATA_WIDTH-1:2], 2'b00};
          we_d     = MemWrite;
          be_d     = MemWrite ? be_new : '0;
          wdata_d  = wdata_new;
          funct3_d = Funct3;
          off_d    = off;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (MemReady) state_d = we_q ? DONE : WAIT_R;
      end
      WAIT_R: begin
        if (MemRValid) begin
          rdata_d = load_ext;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  assign Stall       = (state_q == REQ) || (state_q == WAIT_R) || (state_q == IDLE && start);
  assign ReadData    = rdata_q;
  assign LoadValid   = (state_q == DONE) && !we_q;
  assign AccessFault = fault_q;
  assign MemReq      = (state_q == REQ);
  assign MemWe       = we_q;
  assign MemAddr     = addr_q;
  assign MemByteEn   = be_q;
  assign MemWData    = wdata_q;

endmodule
